// File: rtl/mc_ctrl_fsm.sv
// Main control FSM for the multi-cycle MIPS core: sequences memory, IR, ALU, register file and PC.
// Outputs decode combinationally from the current state; memory states hold until mem_ready.
module mc_ctrl_fsm #(
  parameter int unsigned ILLEGAL_TRAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11,
    StHalt    = 4'd15
  } state_e;

  state_e state_q, state_d;
  logic   pcwrite, branch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    pcsrc    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    illegal  = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        alusrcb = 2'b11;
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default: begin
            illegal = 1'b1;
            state_d = (ILLEGAL_TRAP != 0) ? StHalt : StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        // op can only be lw or sw here; anything else falls back to fetch
        if (op == OpLw)      state_d = StMemRd;
        else if (op == OpSw) state_d = StMemWr;
        else                 state_d = StFetch;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = StFetch;
      end
      StMemWr: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StExecute: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = StAluWb;
      end
      StAluWb: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = StFetch;
      end
      StBranch: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        state_d = StFetch;
      end
      StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        regwrite = 1'b1;
        state_d  = StFetch;
      end
      StJump: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  assign pcen  = pcwrite | (branch & zero);
  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: directed per-cycle vectors push expected outputs, a negedge
// monitor pops and compares. Two instances cover ILLEGAL_TRAP=0 and ILLEGAL_TRAP=1.
module tb_mc_ctrl_fsm;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] op = 6'b0;

  // {state, mem_req, memwrite, iord, irwrite, regwrite, regdst, memtoreg, alusrca,
  //  alusrcb, aluop, pcsrc, pcen, illegal}
  logic [19:0] act0, act1;
  logic [19:0] q0[$], q1[$];
  int errors = 0, checks = 0, cyc = 0;

  logic       mr0, mw0, io0, ir0, rw0, rd0, mt0, sa0, pe0, il0;
  logic [1:0] sb0, ao0, ps0;
  logic [3:0] st0;
  logic       mr1, mw1, io1, ir1, rw1, rd1, mt1, sa1, pe1, il1;
  logic [1:0] sb1, ao1, ps1;
  logic [3:0] st1;

  mc_ctrl_fsm #(.ILLEGAL_TRAP(0)) dut0 (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mr0), .memwrite(mw0), .iord(io0), .irwrite(ir0), .regwrite(rw0), .regdst(rd0),
    .memtoreg(mt0), .alusrca(sa0), .alusrcb(sb0), .aluop(ao0), .pcsrc(ps0), .pcen(pe0),
    .illegal(il0), .state(st0)
  );

  mc_ctrl_fsm #(.ILLEGAL_TRAP(1)) dut1 (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mr1), .memwrite(mw1), .iord(io1), .irwrite(ir1), .regwrite(rw1), .regdst(rd1),
    .memtoreg(mt1), .alusrca(sa1), .alusrcb(sb1), .aluop(ao1), .pcsrc(ps1), .pcen(pe1),
    .illegal(il1), .state(st1)
  );

  assign act0 = {st0, mr0, mw0, io0, ir0, rw0, rd0, mt0, sa0, sb0, ao0, ps0, pe0, il0};
  assign act1 = {st1, mr1, mw1, io1, ir1, rw1, rd1, mt1, sa1, sb1, ao1, ps1, pe1, il1};

  always #5 clk = ~clk;

  // Expected outputs for a given state and inputs, straight from the per-state output table.
  function automatic logic [19:0] expect_vec(input logic [3:0] s, input logic mr, input logic z,
                                             input logic [5:0] o);
    logic req, mw, io, ir, rw, rd, mt, sa, pe, il;
    logic [1:0] sb, ao, ps;
    {req, mw, io, ir, rw, rd, mt, sa, pe, il} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (s)
      4'd0:  begin req = 1; sb = 2'b01; ir = mr; pe = mr; end
      4'd1:  begin
               sb = 2'b11;
               il = !(o == LW || o == SW || o == RT || o == BEQ || o == ADDI || o == JMP);
             end
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin req = 1; io = 1; end
      4'd4:  begin rw = 1; mt = 1; end
      4'd5:  begin req = 1; io = 1; mw = 1; end
      4'd6:  begin sa = 1; ao = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; end
      4'd9:  begin sa = 1; sb = 2'b10; end
      4'd10: rw = 1;
      4'd11: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {s, req, mw, io, ir, rw, rd, mt, sa, sb, ao, ps, pe, il};
  endfunction

  // One cycle: inputs driven just after the edge; s0/s1 are the states each instance must show.
  task automatic step(input logic r, input logic [5:0] o, input logic z, input logic mr,
                      input logic [3:0] s0, input logic [3:0] s1);
    @(posedge clk);
    #1;
    rst = r; op = o; zero = z; mem_ready = mr;
    q0.push_back(expect_vec(s0, mr, z, o));
    q1.push_back(expect_vec(s1, mr, z, o));
  endtask

  task automatic same(input logic [5:0] o, input logic z, input logic mr, input logic [3:0] s);
    step(1'b0, o, z, mr, s, s);
  endtask

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (q0.size() > 0) begin
      logic [19:0] e0, e1;
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      checks = checks + 2;
      if (act0 !== e0) begin
        errors = errors + 1;
        $display("FAIL trap0 cycle %0d: got state=%0d vec=%h, expected state=%0d vec=%h",
                 cyc, act0[19:16], act0, e0[19:16], e0);
      end
      if (act1 !== e1) begin
        errors = errors + 1;
        $display("FAIL trap1 cycle %0d: got state=%0d vec=%h, expected state=%0d vec=%h",
                 cyc, act1[19:16], act1, e1[19:16], e1);
      end
    end
  end

  initial begin
    // reset held with mem_ready low
    for (int i = 0; i < 3; i++) step(1'b1, RT, 1'b0, 1'b0, 4'd0, 4'd0);
    same(RT, 0, 0, 0);
    // lw, no waits: 0,1,2,3,4,0
    same(LW, 0, 1, 0); same(LW, 0, 1, 1); same(LW, 0, 1, 2);
    same(LW, 0, 1, 3); same(LW, 0, 1, 4);
    // R-type
    same(RT, 0, 1, 0); same(RT, 0, 1, 1); same(RT, 0, 1, 6); same(RT, 0, 1, 7);
    // beq taken, then not taken
    same(BEQ, 1, 1, 0); same(BEQ, 1, 1, 1); same(BEQ, 1, 1, 8);
    same(BEQ, 0, 1, 0); same(BEQ, 0, 1, 1); same(BEQ, 0, 1, 8);
    // j and addi
    same(JMP, 0, 1, 0); same(JMP, 0, 1, 1); same(JMP, 0, 1, 11);
    same(ADDI, 0, 1, 0); same(ADDI, 0, 1, 1); same(ADDI, 0, 1, 9); same(ADDI, 0, 1, 10);
    // sw with two wait cycles in MEMWR
    same(SW, 0, 1, 0); same(SW, 0, 1, 1); same(SW, 0, 1, 2);
    same(SW, 0, 0, 5); same(SW, 0, 0, 5); same(SW, 0, 1, 5);
    // lw with waits in FETCH and MEMRD
    same(LW, 0, 0, 0); same(LW, 0, 1, 0); same(LW, 0, 1, 1); same(LW, 0, 1, 2);
    same(LW, 0, 0, 3); same(LW, 0, 1, 3); same(LW, 0, 1, 4);
    // reset mid-store: no write survives
    same(SW, 0, 1, 0); same(SW, 0, 1, 1); same(SW, 0, 1, 2); same(SW, 0, 0, 5);
    step(1'b1, SW, 1'b0, 1'b0, 4'd0, 4'd0);
    same(SW, 0, 0, 0);
    // illegal opcode: instance 0 returns to fetch, instance 1 halts until reset
    same(BAD, 0, 1, 0); same(BAD, 0, 1, 1);
    step(1'b0, BAD, 1'b0, 1'b0, 4'd0, 4'd15);
    step(1'b0, BAD, 1'b0, 1'b1, 4'd0, 4'd15);
    step(1'b0, RT, 1'b0, 1'b1, 4'd1, 4'd15);
    step(1'b1, RT, 1'b0, 1'b0, 4'd0, 4'd0);
    same(RT, 0, 0, 0);
    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && q0.size() > 0; i++) @(posedge clk);
    if (q0.size() > 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d entries left, expected 0", q0.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Main control state machine for the multi-cycle MIPS CPU. It sequences the shared ALU, instruction register, register file, PC and unified memory over several cycles per instruction. It produces the 2-bit aluop consumed by the ALU decoder, plus all datapath mux and write-enable controls. It also holds in memory states until the memory port signals ready.

Parameters:
ILLEGAL_TRAP, 0, 0: an unsupported opcode returns to FETCH after DECODE; 1: it enters HALT and stays there until reset.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
op  in  6  opcode field instr[31:26] from the instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
memwrite  out  1  memory write strobe
iord  out  1  address mux select: 0 = PC, 1 = ALUOut
irwrite  out  1  instruction register load
regwrite  out  1  register file write enable
regdst  out  1  destination select: 1 = rd, 0 = rt
memtoreg  out  1  write-back select: 1 = memory data, 0 = ALUOut
alusrca  out  1  ALU A select: 0 = PC, 1 = register A
alusrcb  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
aluop  out  2  to ALU decoder: 00 = add, 01 = subtract, 10 = use funct
pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
pcen  out  1  PC load enable
illegal  out  1  pulses for one cycle in DECODE when the opcode is unsupported
state  out  4  current state, for debug

Behaviour:
- Supported opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=15
  - Codes 12-14 are unused; if reached, the next state is FETCH.
- rst asserted: state becomes FETCH immediately, at any point including mid-instruction. No partial write completes after reset.
- Outputs are decoded combinationally from state, with mem_ready, op and zero used where listed. Every output not listed for a state is 0.
- Output values after reset (FETCH, mem_ready=0): alusrcb=01, mem_req=1, all other outputs 0, state=0.
- Per-state outputs and transitions:
  - FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=mem_ready, pcwrite=mem_ready. Goes to DECODE when mem_ready=1, otherwise stays.
  - DECODE: alusrcb=11, aluop=00 (precomputes the branch target).
    - lw or sw -> MEMADR; R-type -> EXECUTE; beq -> BRANCH; addi -> ADDIEX; j -> JUMP.
    - Other opcode: illegal=1, then FETCH (ILLEGAL_TRAP=0) or HALT (ILLEGAL_TRAP=1).
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD if op=lw, to MEMWR if op=sw.
  - MEMRD: mem_req=1, iord=1. Goes to MEMWB when mem_ready=1.
  - MEMWB: regwrite=1, regdst=0, memtoreg=1. Goes to FETCH.
  - MEMWR: mem_req=1, iord=1, memwrite=1; both held every cycle until mem_ready=1. Goes to FETCH when mem_ready=1.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10. Goes to ALUWB.
  - ALUWB: regwrite=1, regdst=1, memtoreg=0. Goes to FETCH.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 (internal). Goes to FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00. Goes to ADDIWB.
  - ADDIWB: regwrite=1, regdst=0, memtoreg=0. Goes to FETCH.
  - JUMP: pcsrc=10, pcwrite=1. Goes to FETCH.
  - HALT: all outputs 0. Stays in HALT until reset.
- pcen = pcwrite | (branch & zero), combinational, with no register stage.
- Cycle counts with mem_ready held at 1:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
  - Each memory state adds one cycle per wait cycle (mem_ready=0).
- op is sampled only in DECODE and MEMADR. The IR is stable in those states because irwrite=0.

Test Plan:
- Reset and wait: assert rst with mem_ready=0 for 3 cycles, then release. Required: state=0, mem_req=1, irwrite=0, pcen=0, alusrcb=01.
- lw, mem_ready=1: required state sequence 0,1,2,3,4,0. regwrite=1 with memtoreg=1 in state 4 only. irwrite=1 for exactly one cycle.
- R-type with mem_ready=1: EXECUTE shows aluop=10, alusrca=1, alusrcb=00. ALUWB shows regwrite=1, regdst=1. Back in FETCH after 4 cycles.
- beq: with zero=1, pcen=1 and pcsrc=01 in BRANCH. With zero=0, pcen=0 in BRANCH. Both cases return to FETCH.
- sw with mem_ready low for 2 cycles in MEMWR: memwrite=1 for 3 consecutive cycles, FETCH on the following cycle, regwrite never asserted.
- Illegal opcode 111111: with ILLEGAL_TRAP=0, illegal pulses once in DECODE and the FSM returns to FETCH. With ILLEGAL_TRAP=1, state=15 and stays there until rst; mid-HALT rst returns state to 0.
